// File: rtl/prim_ram_2p_fill_check.sv
// prim_ram_2p_fill_check
//   Drives one port of a two-port RAM to fill every word with an
//   address-salted pattern (pattern ^ addr), then reads every word back
//   and compares it. Reports a sticky error flag, the first failing
//   address and a saturating mismatch count.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   start_i, pattern_i     run request pulse and base pattern (sampled on accept)
//   busy_o, done_o         run in progress / one-cycle completion pulse
//   err_o, err_addr_o,     sticky mismatch flag, first failing address,
//   err_cnt_o              saturating mismatch count
//   ram_*                  single-port RAM initiator interface
module prim_ram_2p_fill_check #(
  parameter int Width = 32,
  parameter int Depth = 128,
  localparam int Aw = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Width-1:0] pattern_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [Aw-1:0]    err_addr_o,
  output logic [Aw:0]      err_cnt_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic             ram_gnt_i,
  input  logic [Width-1:0] ram_rdata_i
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);
  localparam logic [Aw:0]   CntMax   = '1;

  state_e           state_q, state_d;
  logic [Width-1:0] pattern_q, pattern_d;
  logic [Aw-1:0]    addr_q, addr_d;
  logic             pend_q, pend_d;
  logic [Aw-1:0]    cmp_addr_q, cmp_addr_d;
  logic             err_q, err_d;
  logic [Aw-1:0]    err_addr_q, err_addr_d;
  logic [Aw:0]      err_cnt_q, err_cnt_d;

  logic             accept;
  logic             mismatch;

  function automatic logic [Width-1:0] expected(input logic [Width-1:0] pat,
                                                input logic [Aw-1:0] a);
    return pat ^ Width'(a);
  endfunction

  // Request is a pure function of state so an asynchronous reset removes it
  // immediately, without waiting for a clock edge.
  assign ram_req_o   = (state_q == StWrite) || (state_q == StRead);
  assign ram_write_o = (state_q == StWrite);
  assign ram_addr_o  = ram_req_o ? addr_q : '0;
  assign ram_wdata_o = (state_q == StWrite) ? expected(pattern_q, addr_q) : '0;
  assign ram_wmask_o = '1;

  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;

  assign accept = ram_req_o && ram_gnt_i;
  // Read data returns exactly one cycle after an accepted read, whatever the
  // grant does in that cycle, so the compare is keyed only on the pending flag.
  assign mismatch = pend_q && (ram_rdata_i != expected(pattern_q, cmp_addr_q));

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    addr_d     = addr_q;
    pend_d     = 1'b0;
    cmp_addr_d = cmp_addr_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;

    if (mismatch) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_addr_d = cmp_addr_q;
      end
      if (err_cnt_q != CntMax) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          pattern_d  = pattern_i;
          addr_d     = '0;
          err_d      = 1'b0;
          err_addr_d = '0;
          err_cnt_d  = '0;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (accept) begin
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            state_d = StRead;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StRead: begin
        if (accept) begin
          pend_d     = 1'b1;
          cmp_addr_d = addr_q;
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            state_d = StDrain;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      // The last read was accepted on the edge that entered this state, so
      // its compare happens during this single cycle.
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pattern_q  <= '0;
      addr_q     <= '0;
      pend_q     <= 1'b0;
      cmp_addr_q <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      cmp_addr_q <= cmp_addr_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_prim_ram_2p_fill_check.sv
// Directed/randomised bench for prim_ram_2p_fill_check with Depth=8.
// A behavioural RAM (array plus per-address corruption masks) serves the
// DUT; expected results are derived from the corruption table.
module tb_prim_ram_2p_fill_check;
  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [W-1:0]  pattern_i = '0;
  logic          busy_o, done_o, err_o;
  logic [AW-1:0] err_addr_o;
  logic [AW:0]   err_cnt_o;
  logic          ram_req_o, ram_write_o;
  logic [AW-1:0] ram_addr_o;
  logic [W-1:0]  ram_wdata_o, ram_wmask_o;
  logic          ram_gnt_i = 1'b1;
  logic [W-1:0]  ram_rdata_i;

  prim_ram_2p_fill_check #(.Width(W), .Depth(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pattern_i(pattern_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_addr_o(err_addr_o),
    .err_cnt_o(err_cnt_o), .ram_req_o(ram_req_o), .ram_write_o(ram_write_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o),
    .ram_gnt_i(ram_gnt_i), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  int           n_assert = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           start_cyc = 0;
  int           done_cnt = 0;
  int           wr_cnt   = 0;
  logic [W-1:0] pat_ref  = '0;
  logic [W-1:0] mem     [DEPTH];
  logic [W-1:0] corrupt [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM model plus interface monitors
  logic          prev_v = 1'b0;
  logic          prev_req, prev_gnt;
  logic [W+AW:0] prev_bus;

  always @(posedge clk) begin
    cyc++;
    if (done_o) done_cnt++;
    if (ram_req_o && ram_gnt_i) begin
      if (ram_write_o) begin
        mem[ram_addr_o] <= ram_wdata_o;
        wr_cnt++;
        check("wdata", ram_wdata_o, pat_ref ^ W'(ram_addr_o));
        check("wmask", ram_wmask_o, {W{1'b1}});
      end else begin
        ram_rdata_i <= mem[ram_addr_o] ^ corrupt[ram_addr_o];
      end
    end
    if (!rst_i && prev_v && prev_req && !prev_gnt)
      check("hold_ungranted", {ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o},
            {1'b1, prev_bus});
    prev_req = ram_req_o;
    prev_gnt = ram_gnt_i;
    prev_bus = {ram_write_o, ram_addr_o, ram_wdata_o};
    prev_v   = !rst_i;
  end

  task automatic do_start(input logic [W-1:0] p);
    @(negedge clk);
    start_i   = 1'b1;
    pattern_i = p;
    pat_ref   = p;
    start_cyc = cyc;
    @(negedge clk);
    start_i   = 1'b0;
    pattern_i = ~p;
  endtask

  task automatic wait_done(input bit rnd, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_o) begin
        lat = cyc - start_cyc;
        break;
      end
      if (rnd) ram_gnt_i = 1'($urandom_range(0, 1));
    end
    ram_gnt_i = 1'b1;
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  task automatic check_results(input string tag);
    int           exp_cnt = 0;
    logic [AW-1:0] exp_first = '0;
    bit           found = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (corrupt[a] != '0) begin
        exp_cnt++;
        if (!found) exp_first = AW'(a);
        found = 1;
      end
    end
    check({tag, "_err"}, err_o, exp_cnt > 0);
    check({tag, "_err_cnt"}, err_cnt_o, exp_cnt);
    check({tag, "_err_addr"}, err_addr_o, exp_first);
  endtask

  task automatic clean_ram();
    for (int a = 0; a < DEPTH; a++) corrupt[a] = '0;
  endtask

  task automatic full_run(input string tag, input logic [W-1:0] p);
    int lat;
    int d0 = done_cnt;
    do_start(p);
    check({tag, "_busy"}, busy_o, 1);
    wait_done(0, lat);
    check({tag, "_latency"}, lat, 2 * DEPTH + 2);
    @(negedge clk);
    check({tag, "_done_pulse"}, {done_o, busy_o}, 2'b00);
    repeat (3) @(negedge clk);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check_results(tag);
    $display("run %s pattern=%08h latency=%0d err=%0b err_addr=%0d err_cnt=%0d",
             tag, p, lat, err_o, err_addr_o, err_cnt_o);
  endtask

  initial begin
    int lat;
    int d0;
    int w0;
    logic [W-1:0] p;
    clean_ram();
    #1;
    check("reset_outputs", {busy_o, done_o, err_o, err_addr_o, err_cnt_o, ram_req_o,
          ram_write_o, ram_addr_o, ram_wdata_o}, '0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    // Ideal RAM, grant tied high
    w0 = wr_cnt;
    full_run("clean", 32'hA5A5_0000);
    check("clean_writes", wr_cnt - w0, DEPTH);

    // Single corrupted read at address 5
    corrupt[5] = 32'h0000_0008;
    full_run("corrupt5", 32'hA5A5_0000);

    // Two corrupted reads; the first failing address must be reported
    clean_ram();
    corrupt[2] = 32'h0000_0100;
    corrupt[6] = 32'h8000_0000;
    full_run("corrupt26", 32'hA5A5_0000);
    clean_ram();
    full_run("cleared", 32'h1234_5678);

    // start_i during the done cycle is ignored
    do_start(32'hCAFE_0000);
    wait_done(0, lat);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("start_in_done_ignored", {busy_o, done_o}, 2'b00);
    $display("done-cycle start latency=%0d busy=%0b", lat, busy_o);

    // Random 50% grant
    p  = $urandom();
    d0 = done_cnt;
    w0 = wr_cnt;
    do_start(p);
    wait_done(1, lat);
    repeat (3) @(negedge clk);
    check("rnd_done_count", done_cnt - d0, 1);
    check("rnd_writes", wr_cnt - w0, DEPTH);
    check_results("rnd");
    for (int a = 0; a < DEPTH; a++) check("rnd_mem", mem[a], p ^ W'(a));
    $display("random-grant run pattern=%08h latency=%0d err_cnt=%0d", p, lat, err_cnt_o);

    // start_i pulsed mid-WRITE and mid-READ
    p  = $urandom();
    d0 = done_cnt;
    do_start(p);
    repeat (3) @(negedge clk);
    check("mid_write_state", {ram_req_o, ram_write_o}, 2'b11);
    start_i = 1'b1;
    pattern_i = ~p;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_read_state", {ram_req_o, ram_write_o}, 2'b10);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(0, lat);
    check("busy_start_latency", lat, 2 * DEPTH + 2);
    repeat (3) @(negedge clk);
    check("busy_start_done_count", done_cnt - d0, 1);
    check_results("busy_start");
    for (int a = 0; a < DEPTH; a++) check("busy_start_mem", mem[a], p ^ W'(a));
    $display("ignored-start run pattern=%08h latency=%0d", p, lat);

    // Reset mid-READ after an error has been recorded
    corrupt[1] = 32'h0000_0001;
    do_start(32'h0F0F_0F0F);
    repeat (12) @(negedge clk);
    check("pre_reset_read", {ram_req_o, ram_write_o, err_o}, 3'b101);
    rst_i = 1'b1;
    #1;
    check("reset_async_req", ram_req_o, 0);
    check("reset_mid_outputs", {busy_o, done_o, err_o, err_addr_o, err_cnt_o,
          ram_write_o, ram_addr_o, ram_wdata_o}, '0);
    $display("reset mid-read: req=%0b busy=%0b err=%0b", ram_req_o, busy_o, err_o);
    @(negedge clk);
    rst_i = 1'b0;
    clean_ram();
    full_run("after_reset", 32'h7777_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
